// File: rtl/demux_frame_sequencer.sv
// Serial-to-demux sequencer: routes one consumed bit per valid cycle to the
// next demux channel and assembles the N bits into a parallel frame word that
// is held with a valid/ack handshake.
module demux_frame_sequencer #(
    parameter int unsigned SEL_W     = 3,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic                  i_din,
    input  logic                  i_din_valid,
    input  logic                  i_frame_ack,
    output logic                  o_dmx_a,
    output logic                  o_dmx_en,
    output logic [SEL_W-1:0]      o_dmx_s,
    output logic [(2**SEL_W)-1:0] o_frame,
    output logic                  o_frame_valid,
    output logic                  o_busy,
    output logic                  o_ovf
);

    localparam int unsigned N = 2 ** SEL_W;

    // Channel order: ascending from 0, or descending from N-1.
    localparam logic [SEL_W-1:0] FirstCh = MSB_FIRST ? {SEL_W{1'b1}} : {SEL_W{1'b0}};
    localparam logic [SEL_W-1:0] LastCh  = MSB_FIRST ? {SEL_W{1'b0}} : {SEL_W{1'b1}};

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e           r_state;
    state_e           w_state_d;
    logic [SEL_W-1:0] r_ch;
    logic [SEL_W-1:0] w_ch_d;
    logic             r_dmx_a;
    logic             w_dmx_a_d;
    logic             r_dmx_en;
    logic             w_dmx_en_d;
    logic [SEL_W-1:0] r_dmx_s;
    logic [SEL_W-1:0] w_dmx_s_d;
    logic [N-1:0]     r_frame;
    logic [N-1:0]     w_frame_d;
    logic             r_frame_valid;
    logic             w_frame_valid_d;
    logic             r_ovf;
    logic             w_ovf_d;

    // State and output registers; all outputs except busy come straight from here.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= StIdle;
            r_ch          <= FirstCh;
            r_dmx_a       <= 1'b0;
            r_dmx_en      <= 1'b0;
            r_dmx_s       <= {SEL_W{1'b0}};
            r_frame       <= {N{1'b0}};
            r_frame_valid <= 1'b0;
            r_ovf         <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_ch          <= w_ch_d;
            r_dmx_a       <= w_dmx_a_d;
            r_dmx_en      <= w_dmx_en_d;
            r_dmx_s       <= w_dmx_s_d;
            r_frame       <= w_frame_d;
            r_frame_valid <= w_frame_valid_d;
            r_ovf         <= w_ovf_d;
        end
    end

    // Next-state and next-output decode; abort overrides every other request.
    always_comb begin
        w_state_d       = r_state;
        w_ch_d          = r_ch;
        w_dmx_a_d       = 1'b0;
        w_dmx_en_d      = 1'b0;
        w_dmx_s_d       = r_dmx_s;
        w_frame_d       = r_frame;
        w_frame_valid_d = r_frame_valid;
        w_ovf_d         = 1'b0;

        if (i_abort) begin
            w_state_d       = StIdle;
            w_ch_d          = FirstCh;
            w_frame_d       = {N{1'b0}};
            w_frame_valid_d = 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    // A bit presented together with start is not consumed.
                    if (i_start) begin
                        w_state_d = StShift;
                        w_ch_d    = FirstCh;
                        w_frame_d = {N{1'b0}};
                    end
                end
                StShift: begin
                    if (i_din_valid) begin
                        w_dmx_a_d        = i_din;
                        w_dmx_s_d        = r_ch;
                        w_dmx_en_d       = 1'b1;
                        w_frame_d[r_ch]  = i_din;
                        w_ch_d           = MSB_FIRST ? (r_ch - 1'b1) : (r_ch + 1'b1);
                        if (r_ch == LastCh) begin
                            w_frame_valid_d = 1'b1;
                            w_state_d       = StDone;
                        end
                    end
                end
                StDone: begin
                    // Frame is held; any further bit is dropped and flagged.
                    if (i_din_valid) begin
                        w_ovf_d = 1'b1;
                    end
                    if (i_frame_ack) begin
                        w_frame_valid_d = 1'b0;
                        w_state_d       = StIdle;
                    end
                end
                default: begin
                    w_state_d = StIdle;
                    w_ch_d    = FirstCh;
                end
            endcase
        end
    end

    assign o_dmx_a       = r_dmx_a;
    assign o_dmx_en      = r_dmx_en;
    assign o_dmx_s       = r_dmx_s;
    assign o_frame       = r_frame;
    assign o_frame_valid = r_frame_valid;
    assign o_ovf         = r_ovf;
    assign o_busy        = (r_state == StShift) || (r_state == StDone);

endmodule

// File: tb/tb_demux_frame_sequencer.sv
// Bench for demux_frame_sequencer: two instances (ascending and descending
// channel order) share one stimulus stream and are checked every cycle against
// a queue-based reference model, plus a directed vector table and corner cases.
module tb_demux_frame_sequencer;

    localparam int N = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic din = 1'b0;
    logic din_valid = 1'b0;
    logic frame_ack = 1'b0;

    logic       a0, en0, fv0, busy0, ovf0;
    logic [2:0] s0;
    logic [7:0] f0;
    logic       a1, en1, fv1, busy1, ovf1;
    logic [2:0] s1;
    logic [7:0] f1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    demux_frame_sequencer #(.SEL_W(3), .MSB_FIRST(1'b0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort), .i_din(din),
        .i_din_valid(din_valid), .i_frame_ack(frame_ack), .o_dmx_a(a0), .o_dmx_en(en0),
        .o_dmx_s(s0), .o_frame(f0), .o_frame_valid(fv0), .o_busy(busy0), .o_ovf(ovf0)
    );

    demux_frame_sequencer #(.SEL_W(3), .MSB_FIRST(1'b1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort), .i_din(din),
        .i_din_valid(din_valid), .i_frame_ack(frame_ack), .o_dmx_a(a1), .o_dmx_en(en1),
        .o_dmx_s(s1), .o_frame(f1), .o_frame_valid(fv1), .o_busy(busy1), .o_ovf(ovf1)
    );

    // Reference model: a frame is "open" while collecting, "held" once N bits are in.
    bit         m_open, m_held;
    bit         m_bits[$];
    logic       m_a, m_en, m_ovf, m_fv;
    logic [2:0] m_s0, m_s1;
    logic [7:0] m_f0, m_f1;

    function automatic logic [15:0] pk(logic a, logic en, logic [2:0] s, logic [7:0] f,
                                       logic fv, logic busy, logic ovf);
        return {a, en, s, f, fv, busy, ovf};
    endfunction

    function automatic logic [7:0] frame_of(bit descending);
        logic [7:0] f = 8'h00;
        for (int i = 0; i < m_bits.size(); i++) begin
            f[descending ? (N - 1 - i) : i] = m_bits[i];
        end
        return f;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_open = 0;
        m_held = 0;
        m_bits.delete();
        m_a = 0; m_en = 0; m_ovf = 0; m_fv = 0;
        m_s0 = 0; m_s1 = 0; m_f0 = 0; m_f1 = 0;
    endtask

    task automatic model_step(bit st, bit ab, bit d, bit dv, bit ack);
        int k;
        m_a = 0; m_en = 0; m_ovf = 0;
        if (ab) begin
            m_open = 0; m_held = 0; m_fv = 0;
            m_bits.delete();
            m_f0 = 0; m_f1 = 0;
        end else if (m_open) begin
            if (dv) begin
                k = m_bits.size();
                m_bits.push_back(d);
                m_en = 1; m_a = d;
                m_s0 = 3'(k);
                m_s1 = 3'(N - 1 - k);
                m_f0 = frame_of(1'b0);
                m_f1 = frame_of(1'b1);
                if (m_bits.size() == N) begin
                    m_open = 0; m_held = 1; m_fv = 1;
                end
            end
        end else if (m_held) begin
            if (dv) m_ovf = 1;
            if (ack) begin
                m_held = 0; m_fv = 0;
            end
        end else if (st) begin
            m_open = 1;
            m_bits.delete();
            m_f0 = 0; m_f1 = 0;
        end
    endtask

    // One clock: drive at the falling edge, sample at the next falling edge.
    task automatic cycle(bit st, bit ab, bit d, bit dv, bit ack);
        start = st; abort = ab; din = d; din_valid = dv; frame_ack = ack;
        model_step(st, ab, d, dv, ack);
        @(posedge clk);
        @(negedge clk);
        check("dut0_vs_model", {16'h0, pk(a0, en0, s0, f0, fv0, busy0, ovf0)},
              {16'h0, pk(m_a, m_en, m_s0, m_f0, m_fv, m_open | m_held, m_ovf)});
        check("dut1_vs_model", {16'h0, pk(a1, en1, s1, f1, fv1, busy1, ovf1)},
              {16'h0, pk(m_a, m_en, m_s1, m_f1, m_fv, m_open | m_held, m_ovf)});
    endtask

    typedef struct {
        logic [4:0]  in;   // {start, abort, din, din_valid, frame_ack}
        logic [15:0] exp;  // {a, en, s, frame, frame_valid, busy, ovf} for ascending order
    } vec_t;

    vec_t tbl[14];
    bit   stream[8];

    initial begin
        tbl[0]  = '{5'b10000, {1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0}};
        tbl[1]  = '{5'b00110, {1'b1, 1'b1, 3'd0, 8'h01, 1'b0, 1'b1, 1'b0}};
        tbl[2]  = '{5'b00010, {1'b0, 1'b1, 3'd1, 8'h01, 1'b0, 1'b1, 1'b0}};
        tbl[3]  = '{5'b00110, {1'b1, 1'b1, 3'd2, 8'h05, 1'b0, 1'b1, 1'b0}};
        tbl[4]  = '{5'b00110, {1'b1, 1'b1, 3'd3, 8'h0D, 1'b0, 1'b1, 1'b0}};
        tbl[5]  = '{5'b00010, {1'b0, 1'b1, 3'd4, 8'h0D, 1'b0, 1'b1, 1'b0}};
        tbl[6]  = '{5'b00010, {1'b0, 1'b1, 3'd5, 8'h0D, 1'b0, 1'b1, 1'b0}};
        tbl[7]  = '{5'b00110, {1'b1, 1'b1, 3'd6, 8'h4D, 1'b0, 1'b1, 1'b0}};
        tbl[8]  = '{5'b00010, {1'b0, 1'b1, 3'd7, 8'h4D, 1'b1, 1'b1, 1'b0}};
        tbl[9]  = '{5'b00110, {1'b0, 1'b0, 3'd7, 8'h4D, 1'b1, 1'b1, 1'b1}};
        tbl[10] = '{5'b10000, {1'b0, 1'b0, 3'd7, 8'h4D, 1'b1, 1'b1, 1'b0}};
        tbl[11] = '{5'b00010, {1'b0, 1'b0, 3'd7, 8'h4D, 1'b1, 1'b1, 1'b1}};
        tbl[12] = '{5'b10001, {1'b0, 1'b0, 3'd7, 8'h4D, 1'b0, 1'b0, 1'b0}};
        tbl[13] = '{5'b00110, {1'b0, 1'b0, 3'd7, 8'h4D, 1'b0, 1'b0, 1'b0}};
        stream = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset values while rst_n is held low.
        model_reset();
        #1;
        check("reset_dut0", {16'h0, pk(a0, en0, s0, f0, fv0, busy0, ovf0)}, 32'h0);
        check("reset_dut1", {16'h0, pk(a1, en1, s1, f1, fv1, busy1, ovf1)}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(0, 0, 0, 0, 0);

        // Directed table: full frame, overflow in DONE, start ignored, ack+start.
        for (int i = 0; i < 14; i++) begin
            cycle(tbl[i].in[4], tbl[i].in[3], tbl[i].in[2], tbl[i].in[1], tbl[i].in[0]);
            check($sformatf("tbl_%0d", i), {16'h0, pk(a0, en0, s0, f0, fv0, busy0, ovf0)},
                  {16'h0, tbl[i].exp});
        end
        check("tbl_desc_frame", {24'h0, f1}, 32'hB2);

        // Same stream with random gaps; frame held 5 cycles before ack.
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 3)) begin
                cycle(0, 0, 1, 0, 0);
                check("gap_no_en", {31'h0, en0}, 32'h0);
            end
            cycle(0, 0, stream[i], 1, 0);
            check("gap_sel", {29'h0, s0}, i);
        end
        check("gap_frame", {24'h0, f0}, 32'h4D);
        repeat (5) begin
            cycle(0, 0, 0, 0, 0);
            check("gap_fv_held", {31'h0, fv0}, 32'h1);
        end
        cycle(0, 0, 0, 0, 1);
        check("gap_idle_busy", {30'h0, busy0, fv0}, 32'h0);

        // Abort after the 4th bit, together with din_valid and start.
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, stream[i], 1, 0);
        cycle(1, 1, 1, 1, 0);
        check("abort_state", {16'h0, pk(a0, en0, 3'd0, f0, fv0, busy0, ovf0)}, 32'h0);
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 1, 1, 0);
        check("abort_restart_ch", {28'h0, en0, s0}, 32'h8);

        // Descending order: 1 followed by zeros lands in bit 7.
        cycle(1, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            cycle(0, 0, (i == 0), 1, 0);
            check("desc_sel", {29'h0, s1}, 7 - i);
        end
        check("desc_frame", {23'h0, fv1, f1}, 32'h180);
        cycle(0, 0, 0, 0, 1);

        // Asynchronous reset mid-frame, while dmx_en is high.
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 1, 0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_dut0", {16'h0, pk(a0, en0, s0, f0, fv0, busy0, ovf0)}, 32'h0);
        check("async_rst_dut1", {16'h0, pk(a1, en1, s1, f1, fv1, busy1, ovf1)}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised traffic against the model.
        repeat (3000) begin
            cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 5) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
